s420_stim_driver: RTL

S420_STIM_DRIVER -- requirements
Module: s420_stim_driver

---
 rtl/s420_stim_driver.sv | 116 +++++++++++
 1 files changed

// File: rtl/s420_stim_driver.sv
// s420_stim_driver: drives P_0/C into a counter/decoder for nsteps cycles and tallies Z responses.
// Optional S420_DRV_FIRST_HIT_EN adds first_hit/first_hit_vld capture of the first Z=1 step.
module s420_stim_driver (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic [16:0] mask,
    input  logic [15:0] nsteps,
    input  logic        Z,
    output logic        P_0,
    output logic [16:0] C,
    output logic        busy,
    output logic        done,
    output logic [15:0] hit_count,
`ifdef S420_DRV_FIRST_HIT_EN
    output logic [15:0] first_hit,
    output logic        first_hit_vld,
`endif
    output logic [15:0] step_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t      r_state;
    logic        r_p0;
    logic [16:0] r_c;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_hit;
    logic [15:0] r_step;
    logic [15:0] r_nsteps;
    logic [15:0] w_step_nxt;
    logic [15:0] w_hit_nxt;
    logic        w_run_end;
`ifdef S420_DRV_FIRST_HIT_EN
    logic [15:0] r_first;
    logic        r_first_vld;
    assign first_hit     = r_first;
    assign first_hit_vld = r_first_vld;
`endif
    assign w_step_nxt = r_step + 16'd1;
    assign w_run_end  = w_step_nxt == r_nsteps;
    // hit_count saturates rather than wrapping on very long runs
    assign w_hit_nxt  = (Z && r_hit != 16'hFFFF) ? r_hit + 16'd1 : r_hit;
    assign P_0        = r_p0;
    assign C          = r_c;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hit_count  = r_hit;
    assign step_count = r_step;
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_p0     <= 1'b0;
            r_c      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= '0;
            r_step   <= '0;
            r_nsteps <= '0;
`ifdef S420_DRV_FIRST_HIT_EN
            r_first     <= '0;
            r_first_vld <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_nsteps <= nsteps;
                        r_hit    <= '0;
                        r_step   <= '0;
                        r_busy   <= 1'b1;
`ifdef S420_DRV_FIRST_HIT_EN
                        r_first     <= '0;
                        r_first_vld <= 1'b0;
`endif
                        if (nsteps != 16'd0) begin
                            r_state <= RUN;
                            r_p0    <= 1'b1;
                            r_c     <= mask;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_hit  <= w_hit_nxt;
                    r_step <= w_step_nxt;
`ifdef S420_DRV_FIRST_HIT_EN
                    if (Z && !r_first_vld) begin
                        r_first     <= r_step;
                        r_first_vld <= 1'b1;
                    end
`endif
                    if (w_run_end) begin
                        r_state <= DONE;
                        r_p0    <= 1'b0;
                        r_c     <= '0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_p0    <= 1'b0;
                    r_c     <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
